// File: rtl/mvm_lanes_pkg.sv
// Shared types and arithmetic helpers for the lane-parallel matrix-vector multiplier.
package mvm_pkg;

  typedef enum logic [2:0] {LOAD_A, LOAD_X, COMPUTE, FLUSH, OUTPUT} state_e;

  // Wide enough that N full-scale products never overflow the accumulator.
  function automatic int acc_w(input int in_w, input int n);
    return 2 * in_w + $clog2(n) + 1;
  endfunction

  // Returns {ovf, value}; the caller keeps the low out_w bits of value.
  function automatic logic [64:0] sat_wrap(input logic signed [63:0] v, input int out_w,
                                           input bit sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    logic               ovf;
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    ovf = (v > hi) || (v < lo);
    r   = v;
    if (sat && (v > hi)) r = hi;
    else if (sat && (v < lo)) r = lo;
    return {ovf, r};
  endfunction

endpackage

// File: rtl/mvm_lanes_mac_lane.sv
// One multiply-accumulate lane: signed multiplier, optional product register,
// accumulator that restarts on the first column of each row.
module mvm_mac_lane
  import mvm_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int ACC_W    = 19,
  parameter int PIPE_MUL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             clr_i,
  input  logic             last_i,
  input  logic [IN_W-1:0]  a_i,
  input  logic [IN_W-1:0]  x_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             done_o
);

  logic signed [2*IN_W-1:0] prod;
  logic signed [2*IN_W-1:0] st_prod;
  logic                     st_valid;
  logic                     st_clr;
  logic                     st_last;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  prod_ext;

  assign prod = $signed(a_i) * $signed(x_i);

  generate
    if (PIPE_MUL != 0) begin : g_pipe
      logic signed [2*IN_W-1:0] prod_q;
      logic                     valid_q;
      logic                     clr_q;
      logic                     last_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          prod_q  <= '0;
          valid_q <= 1'b0;
          clr_q   <= 1'b0;
          last_q  <= 1'b0;
        end else begin
          prod_q  <= prod;
          valid_q <= valid_i;
          clr_q   <= clr_i;
          last_q  <= last_i;
        end
      end
      assign st_prod  = prod_q;
      assign st_valid = valid_q;
      assign st_clr   = clr_q;
      assign st_last  = last_q;
    end else begin : g_comb
      assign st_prod  = prod;
      assign st_valid = valid_i;
      assign st_clr   = clr_i;
      assign st_last  = last_i;
    end
  endgenerate

  assign prod_ext = {{(ACC_W - 2*IN_W){st_prod[2*IN_W-1]}}, st_prod};
  assign acc_d    = st_clr ? prod_ext : acc_q + prod_ext;

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else if (st_valid) acc_q <= acc_d;
  end

  // The completed row sum is taken from acc_d so it lands in the same edge it finishes.
  assign acc_o  = acc_d;
  assign done_o = st_valid && st_last;

endmodule

// File: rtl/mvm_lanes.sv
// Streaming y = A*x engine: loads A then x over one valid/ready port, computes with
// LANES parallel MAC lanes, then streams the M results out with backpressure.
module mvm_lanes
  import mvm_pkg::*;
#(
  parameter int M        = 4,
  parameter int N        = 4,
  parameter int LANES    = 1,
  parameter int IN_W     = 8,
  parameter int OUT_W    = 16,
  parameter int PIPE_MUL = 1,
  parameter int SAT      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_ovf,
  output logic             busy
);

  localparam int G     = M / LANES;
  localparam int DEPTH = G * N;
  localparam int ACC_W = acc_w(IN_W, N);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int YW    = (M > 1) ? $clog2(M) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(N - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
  localparam logic [AW-1:0] BASE_LAST = AW'((G - 1) * N);
  localparam logic [YW-1:0] Y_LAST    = YW'(M - 1);
  localparam logic          FL_LAST   = 1'(PIPE_MUL);

  state_e        state_q;
  logic          s_ready_q, m_valid_q, busy_q;
  logic [CW-1:0] ld_col_q, cp_col_q;
  logic [LW-1:0] ld_lane_q;
  logic [AW-1:0] ld_base_q, cp_base_q;
  logic          fl_cnt_q;
  logic [YW-1:0] out_idx_q, wr_base_q;
  logic          iss_v_q, iss_clr_q, iss_last_q;
  logic          s_acc;
  logic [AW-1:0] wr_addr, rd_addr;

  logic [IN_W-1:0]  xmem [N];
  logic [IN_W-1:0]  x_rd_q;
  logic [OUT_W-1:0] y_q [M];
  logic [M-1:0]     yovf_q;

  logic [LANES-1:0][ACC_W-1:0] lane_acc;
  logic [LANES-1:0]            lane_done;
  logic [LANES-1:0][OUT_W-1:0] res;
  logic [LANES-1:0]            res_ovf;
  logic                        grp_done;

  assign s_acc   = s_valid && s_ready_q;
  assign wr_addr = ld_base_q + AW'(ld_col_q);
  assign rd_addr = cp_base_q + AW'(cp_col_q);

  always_ff @(posedge clk) begin
    if (state_q == LOAD_X && s_acc) xmem[ld_col_q] <= s_data;
    x_rd_q <= xmem[cp_col_q];
  end

  // Lane gi owns rows gi, gi+LANES, ... so each lane reads its own bank in lockstep.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [IN_W-1:0] bank [DEPTH];
      logic [IN_W-1:0] a_rd_q;
      logic [64:0]     sw;
      logic            lane_unused;

      always_ff @(posedge clk) begin
        if (state_q == LOAD_A && s_acc && ld_lane_q == LW'(gi)) bank[wr_addr] <= s_data;
        a_rd_q <= bank[rd_addr];
      end

      mvm_mac_lane #(
        .IN_W    (IN_W),
        .ACC_W   (ACC_W),
        .PIPE_MUL(PIPE_MUL)
      ) u_lane (
        .clk    (clk),
        .reset  (reset),
        .valid_i(iss_v_q),
        .clr_i  (iss_clr_q),
        .last_i (iss_last_q),
        .a_i    (a_rd_q),
        .x_i    (x_rd_q),
        .acc_o  (lane_acc[gi]),
        .done_o (lane_done[gi])
      );

      assign sw          = sat_wrap(64'($signed(lane_acc[gi])), OUT_W, SAT != 0);
      assign res[gi]     = sw[OUT_W-1:0];
      assign res_ovf[gi] = sw[64];
      assign lane_unused = ^sw[63:OUT_W];
    end
  endgenerate

  assign grp_done = &lane_done;

  always_ff @(posedge clk) begin
    if (reset || (state_q != COMPUTE && state_q != FLUSH)) wr_base_q <= '0;
    else if (grp_done) wr_base_q <= wr_base_q + YW'(LANES);
  end

  always_ff @(posedge clk) begin
    if (grp_done) begin
      for (int l = 0; l < LANES; l++) begin
        y_q[YW'(int'(wr_base_q) + l)]    <= res[l];
        yovf_q[YW'(int'(wr_base_q) + l)] <= res_ovf[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD_A;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      ld_col_q   <= '0;
      ld_lane_q  <= '0;
      ld_base_q  <= '0;
      cp_col_q   <= '0;
      cp_base_q  <= '0;
      fl_cnt_q   <= 1'b0;
      out_idx_q  <= '0;
      iss_v_q    <= 1'b0;
      iss_clr_q  <= 1'b0;
      iss_last_q <= 1'b0;
    end else begin
      iss_v_q    <= (state_q == COMPUTE);
      iss_clr_q  <= (cp_col_q == '0);
      iss_last_q <= (cp_col_q == COL_LAST);
      case (state_q)
        LOAD_A: begin
          s_ready_q <= 1'b1;
          if (s_acc) begin
            if (ld_col_q == COL_LAST) begin
              ld_col_q <= '0;
              if (ld_lane_q == LANE_LAST) begin
                ld_lane_q <= '0;
                if (ld_base_q == BASE_LAST) begin
                  ld_base_q <= '0;
                  state_q   <= LOAD_X;
                end else begin
                  ld_base_q <= ld_base_q + AW'(N);
                end
              end else begin
                ld_lane_q <= ld_lane_q + LW'(1);
              end
            end else begin
              ld_col_q <= ld_col_q + CW'(1);
            end
          end
        end
        LOAD_X: begin
          if (s_acc) begin
            if (ld_col_q == COL_LAST) begin
              ld_col_q  <= '0;
              cp_col_q  <= '0;
              cp_base_q <= '0;
              s_ready_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= COMPUTE;
            end else begin
              ld_col_q <= ld_col_q + CW'(1);
            end
          end
        end
        COMPUTE: begin
          if (cp_col_q == COL_LAST) begin
            cp_col_q <= '0;
            if (cp_base_q == BASE_LAST) begin
              fl_cnt_q <= 1'b0;
              state_q  <= FLUSH;
            end else begin
              cp_base_q <= cp_base_q + AW'(N);
            end
          end else begin
            cp_col_q <= cp_col_q + CW'(1);
          end
        end
        FLUSH: begin
          if (fl_cnt_q == FL_LAST) begin
            m_valid_q <= 1'b1;
            out_idx_q <= '0;
            state_q   <= OUTPUT;
          end else begin
            fl_cnt_q <= 1'b1;
          end
        end
        OUTPUT: begin
          if (m_valid_q && m_ready) begin
            if (out_idx_q == Y_LAST) begin
              m_valid_q <= 1'b0;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b0;
              out_idx_q <= '0;
              state_q   <= LOAD_A;
            end else begin
              out_idx_q <= out_idx_q + YW'(1);
            end
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign busy    = busy_q;
  assign m_data  = m_valid_q ? y_q[out_idx_q] : '0;
  assign m_ovf   = m_valid_q & yovf_q[out_idx_q];

endmodule

// File: tb/tb_mvm_lanes.sv
// Directed bench for mvm_lanes: four parameterisations share one stimulus port,
// selected by sel; expected results are hand-computed.
module tb_mvm_lanes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       sv, mr;
  logic [7:0] sd;
  int         sel;
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]  s_valid_v, m_ready_v, s_ready_v, m_valid_v, m_ovf_v, busy_v;
  logic [15:0] m_data_v [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      s_valid_v[k] = sv && (sel == k);
      m_ready_v[k] = mr && (sel == k);
    end
  end

  mvm_lanes #(.M(4), .N(4), .LANES(1), .IN_W(8), .OUT_W(16), .PIPE_MUL(1), .SAT(1)) u0 (
    .clk(clk), .reset(reset), .s_valid(s_valid_v[0]), .s_ready(s_ready_v[0]), .s_data(sd),
    .m_valid(m_valid_v[0]), .m_ready(m_ready_v[0]), .m_data(m_data_v[0]), .m_ovf(m_ovf_v[0]),
    .busy(busy_v[0]));
  mvm_lanes #(.M(4), .N(3), .LANES(2), .IN_W(8), .OUT_W(16), .PIPE_MUL(1), .SAT(1)) u1 (
    .clk(clk), .reset(reset), .s_valid(s_valid_v[1]), .s_ready(s_ready_v[1]), .s_data(sd),
    .m_valid(m_valid_v[1]), .m_ready(m_ready_v[1]), .m_data(m_data_v[1]), .m_ovf(m_ovf_v[1]),
    .busy(busy_v[1]));
  mvm_lanes #(.M(4), .N(4), .LANES(1), .IN_W(8), .OUT_W(16), .PIPE_MUL(1), .SAT(0)) u2 (
    .clk(clk), .reset(reset), .s_valid(s_valid_v[2]), .s_ready(s_ready_v[2]), .s_data(sd),
    .m_valid(m_valid_v[2]), .m_ready(m_ready_v[2]), .m_data(m_data_v[2]), .m_ovf(m_ovf_v[2]),
    .busy(busy_v[2]));
  mvm_lanes #(.M(4), .N(4), .LANES(4), .IN_W(8), .OUT_W(16), .PIPE_MUL(0), .SAT(1)) u3 (
    .clk(clk), .reset(reset), .s_valid(s_valid_v[3]), .s_ready(s_ready_v[3]), .s_data(sd),
    .m_valid(m_valid_v[3]), .m_ready(m_ready_v[3]), .m_data(m_data_v[3]), .m_ovf(m_ovf_v[3]),
    .busy(busy_v[3]));

  int checks = 0;
  int errors = 0;
  int a_mem [16];
  int x_mem [4];
  int y_exp [4];
  int ovf_exp [4];
  int last_cyc;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mdata();
    return int'($signed(m_data_v[sel]));
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_elem(input int v);
    int t;
    t  = 0;
    sv = 1'b1;
    sd = 8'(v);
    while (!s_ready_v[sel] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("s_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    sv = 1'b0;
  endtask

  task automatic load_all(input int mm, input int nn, input bit gaps);
    for (int i = 0; i < mm * nn + nn; i++) begin
      if (gaps && (i % 3 == 2)) @(negedge clk);
      send_elem((i < mm * nn) ? a_mem[i] : x_mem[i - mm * nn]);
    end
    last_cyc = cyc;
  endtask

  task automatic run(input string tag, input int mm, input int nn, input int lat,
                     input bit bp, input bit hold);
    int t, idx, k;
    load_all(mm, nn, bp);
    chk({tag, "_sready_after_x"}, int'(s_ready_v[sel]), 0);
    chk({tag, "_busy_after_x"}, int'(busy_v[sel]), 1);
    if (hold) begin
      sv = 1'b1;
      sd = 8'h55;
    end
    t = 0;
    while (!m_valid_v[sel] && t < 300) begin
      @(negedge clk);
      t++;
    end
    sv = 1'b0;
    chk({tag, "_latency"}, cyc - last_cyc, lat);
    idx = 0;
    k   = 0;
    t   = 0;
    while (idx < mm && t < 500) begin
      mr = bp ? (k % 3 == 2) : 1'b1;
      k++;
      t++;
      chk({tag, "_mvalid"}, int'(m_valid_v[sel]), 1);
      chk({tag, "_mdata"}, mdata(), y_exp[idx]);
      chk({tag, "_movf"}, int'(m_ovf_v[sel]), ovf_exp[idx]);
      $display("%s: out[%0d] data=%0d ovf=%0d ready=%0d", tag, idx, mdata(), m_ovf_v[sel], mr);
      if (mr && m_valid_v[sel]) idx++;
      @(posedge clk);
      @(negedge clk);
    end
    mr = 1'b0;
    chk({tag, "_count"}, idx, mm);
    chk({tag, "_mvalid_end"}, int'(m_valid_v[sel]), 0);
    chk({tag, "_sready_end"}, int'(s_ready_v[sel]), 1);
    chk({tag, "_busy_end"}, int'(busy_v[sel]), 0);
  endtask

  initial begin
    sv    = 1'b0;
    mr    = 1'b0;
    sd    = '0;
    sel   = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sready", int'(s_ready_v[0]), 0);
    chk("rst_mvalid", int'(m_valid_v[0]), 0);
    chk("rst_mdata", int'(m_data_v[0]), 0);
    chk("rst_movf", int'(m_ovf_v[0]), 0);
    chk("rst_busy", int'(busy_v[0]), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_release_sready", int'(s_ready_v[0]), 1);

    // Identity matrix, default configuration
    sel = 0;
    for (int i = 0; i < 16; i++) a_mem[i] = ((i / 4) == (i % 4)) ? 1 : 0;
    x_mem   = '{3, -5, 7, -128};
    y_exp   = '{3, -5, 7, -128};
    ovf_exp = '{0, 0, 0, 0};
    run("ident", 4, 4, 18, 1'b0, 1'b0);

    // Two lanes, N=3, s_valid held high past the last x
    sel     = 1;
    a_mem   = '{1, 2, 3, 4, 5, 6, -1, 0, 1, 2, 2, 2, 0, 0, 0, 0};
    x_mem   = '{1, 1, 2, 0};
    y_exp   = '{9, 21, 1, 8};
    ovf_exp = '{0, 0, 0, 0};
    run("m4n3l2", 4, 3, 8, 1'b0, 1'b1);

    // Full-scale positive overflow: saturate, then wrap
    for (int i = 0; i < 16; i++) a_mem[i] = -128;
    x_mem   = '{-128, -128, -128, -128};
    sel     = 0;
    y_exp   = '{32767, 32767, 32767, 32767};
    ovf_exp = '{1, 1, 1, 1};
    run("sat", 4, 4, 18, 1'b0, 1'b0);
    sel     = 2;
    y_exp   = '{0, 0, 0, 0};
    run("wrap", 4, 4, 18, 1'b0, 1'b0);

    // Backpressure on output and gaps on input
    sel = 0;
    for (int i = 0; i < 16; i++) a_mem[i] = ((i / 4) == (i % 4)) ? 1 : 0;
    x_mem   = '{3, -5, 7, -128};
    y_exp   = '{3, -5, 7, -128};
    ovf_exp = '{0, 0, 0, 0};
    run("bp", 4, 4, 18, 1'b1, 1'b0);

    // Reset in the middle of COMPUTE, then a fresh load
    sel   = 0;
    a_mem = '{1, 2, 3, 4, -1, -2, -3, -4, 10, 0, 0, 0, 0, 0, 0, 127};
    x_mem = '{1, 2, 3, 4};
    load_all(4, 4, 1'b0);
    repeat (5) @(negedge clk);
    chk("midrst_busy_before", int'(busy_v[0]), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_mvalid", int'(m_valid_v[0]), 0);
    chk("midrst_busy", int'(busy_v[0]), 0);
    chk("midrst_sready", int'(s_ready_v[0]), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_release_sready", int'(s_ready_v[0]), 1);
    y_exp   = '{30, -30, 10, 508};
    ovf_exp = '{0, 0, 0, 0};
    run("after_rst", 4, 4, 18, 1'b0, 1'b0);

    // Combinational multiply, one group of four lanes
    sel = 3;
    a_mem = '{1, 2, 3, 4, -1, -2, -3, -4, 127, 127, 127, 127, -128, -128, -128, -128};
    x_mem   = '{1, 2, 3, 4};
    y_exp   = '{30, -30, 1270, -1280};
    ovf_exp = '{0, 0, 0, 0};
    run("l4p0", 4, 4, 5, 1'b0, 1'b0);
    x_mem   = '{-128, -128, -128, -128};
    y_exp   = '{-1280, 1280, -32768, 32767};
    ovf_exp = '{0, 0, 1, 1};
    run("l4p0_sat", 4, 4, 5, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
